// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide add sequencer: word width, FSM state
// encoding and a helper that sizes index/counter registers.
package wide_add_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wide_add_seq.sv
// wide_add_seq: feeds a wide operand pair word by word (LSW first) to an
// external registered 32-bit adder, chaining carry-out into the next carry-in,
// and presents the assembled wide sum on a valid/ready output.
// Optional feature macro: OVF_DETECT_EN adds out_ovf (signed overflow flag).
//
// Operand words for word k are registered on the edge that enters ISSUE, so the
// adder sees them during the ISSUE cycle; the returned sum is captured on the
// last of ADD_LAT WAIT cycles. Per-word cost is therefore ADD_LAT+1 cycles.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NWORDS  = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W*NWORDS-1:0]   in_a,
    input  logic [WORD_W*NWORDS-1:0]   in_b,
    input  logic                       in_cin,
    output logic [WORD_W-1:0]          add_a,
    output logic [WORD_W-1:0]          add_b,
    output logic                       add_cin,
    input  logic [WORD_W-1:0]          add_sum,
    input  logic                       add_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W*NWORDS-1:0]   out_sum,
    output logic                       out_cout
`ifdef OVF_DETECT_EN
    ,
    output logic                       out_ovf
`endif
);

    localparam int WIDE_W = WORD_W * NWORDS;
    localparam int KW     = idx_width(NWORDS);
    localparam int CW     = idx_width(ADD_LAT);
    localparam logic [KW-1:0] LAST_K   = KW'(NWORDS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ADD_LAT - 1);

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [KW-1:0]       k_inc;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDE_W-1:0]   a_q, a_d;
    logic [WIDE_W-1:0]   b_q, b_d;
    logic [WORD_W-1:0]   add_a_q, add_a_d;
    logic [WORD_W-1:0]   add_b_q, add_b_d;
    logic                add_cin_q, add_cin_d;
    logic [WIDE_W-1:0]   sum_q, sum_d;
    logic [WIDE_W-1:0]   out_sum_q, out_sum_d;
    logic                out_cout_q, out_cout_d;
`ifdef OVF_DETECT_EN
    logic                ovf_q, ovf_d;
`endif

    // Word-sliced views of the latched operands.
    logic [WORD_W-1:0]   a_word [NWORDS];
    logic [WORD_W-1:0]   b_word [NWORDS];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            assign a_word[gi] = a_q[gi*WORD_W +: WORD_W];
            assign b_word[gi] = b_q[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign k_inc = k_q + KW'(1);

    // Next-state, operand issue and result collection.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_cin_d  = add_cin_q;
        sum_d      = sum_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
`ifdef OVF_DETECT_EN
        ovf_d      = ovf_q;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d       = in_a;
                    b_d       = in_b;
                    k_d       = '0;
                    // Word 0 goes straight out so the adder starts during ISSUE.
                    add_a_d   = in_a[WORD_W-1:0];
                    add_b_d   = in_b[WORD_W-1:0];
                    add_cin_d = in_cin;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    // Adder output is only trusted on this cycle.
                    for (int i = 0; i < NWORDS; i++) begin
                        if (k_q == KW'(i)) begin
                            sum_d[i*WORD_W +: WORD_W] = add_sum;
                        end
                    end
                    if (k_q == LAST_K) begin
                        out_sum_d  = sum_d;
                        out_cout_d = add_cout;
`ifdef OVF_DETECT_EN
                        ovf_d = (a_q[WIDE_W-1] == b_q[WIDE_W-1]) &&
                                (add_sum[WORD_W-1] != a_q[WIDE_W-1]);
`endif
                        state_d    = ST_DONE;
                    end else begin
                        k_d       = k_inc;
                        add_a_d   = a_word[k_inc];
                        add_b_d   = b_word[k_inc];
                        add_cin_d = add_cout;
                        state_d   = ST_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            sum_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
`ifdef OVF_DETECT_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            sum_q      <= sum_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
`ifdef OVF_DETECT_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_cin  = add_cin_q;
    assign out_sum  = out_sum_q;
    assign out_cout = out_cout_q;
`ifdef OVF_DETECT_EN
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq (NWORDS=4, ADD_LAT=2) with a two-stage
// registered 32-bit adder model beside the DUT. OVF_DETECT_EN enables the
// overflow-flag scenario.
module tb_wide_add_seq;

    localparam int NW  = 4;
    localparam int LAT = 2;
    localparam int W   = 32 * NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          in_cin;
    logic [31:0]   add_a, add_b;
    logic          add_cin;
    logic [31:0]   add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
`ifdef OVF_DETECT_EN
    logic          out_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic cin_log [0:63];

    always #5 clk = ~clk;

    wide_add_seq #(.NWORDS(NW), .ADD_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef OVF_DETECT_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // Adder model: two register stages, result visible two cycles after operands.
    logic [32:0] st1, st2;
    always @(posedge clk) begin
        st1 <= {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
        st2 <= st1;
    end
    assign add_sum  = st2[31:0];
    assign add_cout = st2[32];

    // Offer one operand pair, wait (bounded) for out_valid. lat counts posedges
    // from the accept edge through the edge that raises out_valid; 0 = timeout.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           output int lat, output logic [W-1:0] sum,
                           output logic cout, output logic ovf);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            cin_log[n] = add_cin;
            if (out_valid) begin
                lat = n + 1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        sum  = out_sum;
        cout = out_cout;
`ifdef OVF_DETECT_EN
        ovf = out_ovf;
`else
        ovf = 1'b0;
`endif
        $display("txn a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d latency=%0d",
                 a, b, cin, sum, cout, ovf, lat);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (add_a !== 32'h0) begin n_fail++; $display("FAIL reset_add_a got=%h exp=0", add_a); end
        n_checks++; if (add_b !== 32'h0) begin n_fail++; $display("FAIL reset_add_b got=%h exp=0", add_b); end
        n_checks++; if (add_cin !== 1'b0) begin n_fail++; $display("FAIL reset_add_cin got=%b exp=0", add_cin); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
`ifdef OVF_DETECT_EN
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
`endif
    endtask

    // All-ones + 0 + cin=1: carry must ripple through every word.
    task automatic test_carry_chain();
        int lat; logic [W-1:0] s; logic c, o;
        run_txn({W{1'b1}}, '0, 1'b1, lat, s, c, o);
        n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL carry_latency got=%0d exp=13", lat); end
        n_checks++; if (s !== '0) begin n_fail++; $display("FAIL carry_sum got=%h exp=0", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL carry_cout got=%b exp=1", c); end
        for (int k = 1; k < NW; k++) begin
            n_checks++;
            if (cin_log[3*k+1] !== 1'b1) begin
                n_fail++; $display("FAIL carry_add_cin_k%0d got=%b exp=1", k, cin_log[3*k+1]);
            end
        end
        release_out();
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    task automatic test_vectors();
        vec_t v [4];
        int lat; logic [W-1:0] s; logic c, o;
        v[0] = '{128'h00000001_00000000_FFFFFFFF_00000001, 128'h1, 1'b0,
                 128'h00000001_00000000_FFFFFFFF_00000002, 1'b0};
        v[1] = '{128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0,
                 128'h00000000_00000001_00000000_00000000, 1'b0};
        v[2] = '{128'h12345678_9ABCDEF0_0F0F0F0F_F0000000,
                 128'h11111111_11111111_F0F0F0F0_20000000, 1'b0,
                 128'h23456789_ABCDF002_00000000_10000000, 1'b0};
        v[3] = '{128'h80000000_00000000_00000000_00000000,
                 128'h80000000_00000000_00000000_00000000, 1'b0,
                 128'h0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_txn(v[i].a, v[i].b, v[i].cin, lat, s, c, o);
            n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL vec%0d_latency got=%0d exp=13", i, lat); end
            n_checks++; if (s !== v[i].s) begin n_fail++; $display("FAIL vec%0d_sum got=%h exp=%h", i, s, v[i].s); end
            n_checks++; if (c !== v[i].c) begin n_fail++; $display("FAIL vec%0d_cout got=%b exp=%b", i, c, v[i].c); end
            release_out();
        end
    endtask

    // Result must hold while out_ready is low; new operands are ignored meanwhile.
    task automatic test_hold();
        int lat; logic [W-1:0] s; logic c, o;
        logic [W-1:0] exp_s;
        exp_s = 128'h23456789_ABCDF002_00000000_10000000;
        run_txn(128'h12345678_9ABCDEF0_0F0F0F0F_F0000000,
                128'h11111111_11111111_F0F0F0F0_20000000, 1'b0, lat, s, c, o);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = {W{1'b1}}; in_b = {W{1'b1}}; in_cin = 1'b1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            n_checks++; if (out_sum !== exp_s) begin n_fail++; $display("FAIL hold_out_sum cyc=%0d got=%h exp=%h", i, out_sum, exp_s); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        release_out();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); end
    endtask

    // Reset during the WAIT of word 2 must abort with nothing emitted.
    task automatic test_reset_mid();
        int lat; logic [W-1:0] s; logic c, o;
        bit seen_valid;
        @(negedge clk);
        in_a = 128'h12345678_9ABCDEF0_0F0F0F0F_F0000000;
        in_b = 128'h11111111_11111111_F0F0F0F0_20000000;
        in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (add_a !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL midrst_word2_add_a got=%h exp=9abcdef0", add_a); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (add_a !== 32'h0) begin n_fail++; $display("FAIL midrst_add_a got=%h exp=0", add_a); end
        n_checks++; if (add_b !== 32'h0) begin n_fail++; $display("FAIL midrst_add_b got=%h exp=0", add_b); end
        n_checks++; if (add_cin !== 1'b0) begin n_fail++; $display("FAIL midrst_add_cin got=%b exp=0", add_cin); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL midrst_out_sum got=%h exp=0", out_sum); end
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got=%b exp=0", seen_valid); end
        $display("txn aborted by reset in word 2 wait");
        run_txn(128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, lat, s, c, o);
        n_checks++; if (s !== 128'h00000000_00000001_00000000_00000000) begin n_fail++; $display("FAIL midrst_recover_sum got=%h exp=00000000000000010000000000000000", s); end
        release_out();
    endtask

    // in_valid held high, out_ready high: second accept one edge after handshake.
    task automatic test_back_to_back();
        int acc_edge [2];
        int hs_edge  [2];
        logic [W-1:0] hs_sum [2];
        int n_acc, n_hs;
        logic [W-1:0] v1, v2, s1, s2;
        v1 = 128'h00000001_00000000_FFFFFFFF_00000001;
        v2 = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF;
        s1 = 128'h00000001_00000000_FFFFFFFF_00000002;
        s2 = 128'h00000000_00000001_00000000_00000000;
        n_acc = 0; n_hs = 0;
        acc_edge[0] = -1; acc_edge[1] = -1; hs_edge[0] = -1; hs_edge[1] = -1;
        hs_sum[0] = '0; hs_sum[1] = '0;
        @(negedge clk);
        in_a = v1; in_b = 128'h1; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 0; e < 80 && n_hs < 2; e++) begin
            if (in_valid && in_ready && n_acc < 2) begin acc_edge[n_acc] = e; n_acc++; end
            if (out_valid && out_ready) begin hs_edge[n_hs] = e; hs_sum[n_hs] = out_sum; n_hs++; end
            @(posedge clk);
            @(negedge clk);
            if (n_acc == 1) in_a = v2;
            if (n_acc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        $display("txn b2b#1 accept_edge=%0d handshake_edge=%0d sum=%h", acc_edge[0], hs_edge[0], hs_sum[0]);
        $display("txn b2b#2 accept_edge=%0d handshake_edge=%0d sum=%h", acc_edge[1], hs_edge[1], hs_sum[1]);
        n_checks++; if (n_hs !== 2) begin n_fail++; $display("FAIL b2b_handshakes got=%0d exp=2", n_hs); end
        n_checks++; if (hs_edge[0] - acc_edge[0] !== 13) begin n_fail++; $display("FAIL b2b_first_handshake_delay got=%0d exp=13", hs_edge[0] - acc_edge[0]); end
        n_checks++; if (acc_edge[1] - hs_edge[0] !== 1) begin n_fail++; $display("FAIL b2b_reaccept_gap got=%0d exp=1", acc_edge[1] - hs_edge[0]); end
        n_checks++; if (hs_sum[0] !== s1) begin n_fail++; $display("FAIL b2b_sum1 got=%h exp=%h", hs_sum[0], s1); end
        n_checks++; if (hs_sum[1] !== s2) begin n_fail++; $display("FAIL b2b_sum2 got=%h exp=%h", hs_sum[1], s2); end
    endtask

`ifdef OVF_DETECT_EN
    task automatic test_ovf();
        int lat; logic [W-1:0] s; logic c, o;
        run_txn({1'b0, {(W-1){1'b1}}}, 128'h1, 1'b0, lat, s, c, o);
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag got=%b exp=1", o); end
        n_checks++; if (s !== {1'b1, {(W-1){1'b0}}}) begin n_fail++; $display("FAIL ovf_pos_sum got=%h exp=8000...0", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL ovf_pos_cout got=%b exp=0", c); end
        release_out();
        run_txn({W{1'b1}}, 128'h1, 1'b0, lat, s, c, o);
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL ovf_neg1_flag got=%b exp=0", o); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL ovf_neg1_cout got=%b exp=1", c); end
        n_checks++; if (s !== '0) begin n_fail++; $display("FAIL ovf_neg1_sum got=%h exp=0", s); end
        release_out();
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef OVF_DETECT_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
